// File: rtl/poly_lane_combiner.sv
// poly_lane_combiner
//   Combines a sparse, index-tagged polynomial product stream with dense,
//   index-aligned e and b streams into lane-packed sums. Each of LANES lanes
//   is computed modulo 2^LANE_W with no carry between lanes:
//     s = b + e + p   (mode 0)      s = b + e - p   (mode 1)
//   where p = poly lo half (or 0 when the index is missing) plus the hi
//   "spill" half left behind by the poly word of the previous index.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-high reset
//   poly_valid/_in/_idx     poly word: [W-1:0] lo (this index), [2W-1:W] hi (index+1)
//   poly_ready              poly word consumed (MATCH or DROP)
//   e_valid/_in/_idx        dense e stream, index 0..DEPTH-1 in order
//   e_ready, b_ready        e and b consumed together (MATCH or FILL)
//   b_valid/_in             dense b stream, index implied equal to e_idx
//   mode_sub                add/subtract select, captured at the e_idx==0 consume
//   sum_ready               downstream ready
//   sum_valid/sum/sum_idx   registered result word and its index
//   sum_last                result word is index DEPTH-1
//
// Optional build macro PCOMB_STATS_EN adds drop_cnt / fill_cnt outputs
// (saturating per-frame DROP and FILL event counters).

module poly_lane_combiner #(
  parameter int LANES  = 4,
  parameter int LANE_W = 6,
  parameter int DEPTH  = 784,
  parameter int IDX_W  = 10
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      poly_valid,
  input  logic [2*LANES*LANE_W-1:0] poly_in,
  input  logic [IDX_W-1:0]          poly_idx,
  output logic                      poly_ready,
  input  logic                      e_valid,
  input  logic [LANES*LANE_W-1:0]   e_in,
  input  logic [IDX_W-1:0]          e_idx,
  output logic                      e_ready,
  input  logic                      b_valid,
  input  logic [LANES*LANE_W-1:0]   b_in,
  output logic                      b_ready,
  input  logic                      mode_sub,
  input  logic                      sum_ready,
  output logic                      sum_valid,
  output logic [LANES*LANE_W-1:0]   sum,
  output logic [IDX_W-1:0]          sum_idx,
  output logic                      sum_last
`ifdef PCOMB_STATS_EN
  ,
  output logic [IDX_W-1:0]          drop_cnt,
  output logic [IDX_W-1:0]          fill_cnt
`endif
);

  localparam int                W        = LANES * LANE_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  logic             sum_valid_q;
  logic [W-1:0]     sum_q;
  logic [W-1:0]     sum_d;
  logic [IDX_W-1:0] sum_idx_q;
  logic             sum_last_q;
  logic [W-1:0]     spill_q;
  logic [IDX_W-1:0] spill_idx_q;
  logic             spill_vld_q;
  logic             mode_q;

  logic out_free;
  logic streams_ok;
  logic fire_match;
  logic fire_fill;
  logic fire_drop;
  logic fire_emit;
  logic frame_start;
  logic spill_hit;
  logic mode_eff;

  // Stream decision: which of MATCH / FILL / DROP fires this cycle.
  always_comb begin
    out_free    = !sum_valid_q || sum_ready;
    streams_ok  = out_free && b_valid && e_valid;
    fire_match  = streams_ok && poly_valid && (poly_idx == e_idx);
    fire_fill   = streams_ok && poly_valid && (poly_idx > e_idx);
    // DROP only discards stale poly words, so it does not wait on the output.
    fire_drop   = poly_valid && (poly_idx < e_idx);
    fire_emit   = fire_match || fire_fill;
    frame_start = (e_idx == '0);
    // At frame start any leftover spill belongs to the previous frame.
    spill_hit   = spill_vld_q && !frame_start && (spill_idx_q == e_idx - IDX_W'(1));
    // The first word of a frame already uses the newly sampled mode.
    mode_eff    = frame_start ? mode_sub : mode_q;
  end

  assign poly_ready = fire_match || fire_drop;
  assign e_ready    = fire_emit;
  assign b_ready    = fire_emit;

  // Per-lane modular arithmetic for the word being emitted.
  always_comb begin
    logic [LANE_W-1:0] lo_l;
    logic [LANE_W-1:0] sp_l;
    logic [LANE_W-1:0] p_l;
    logic [LANE_W-1:0] be_l;
    sum_d = '0;
    for (int l = 0; l < LANES; l++) begin
      lo_l = fire_match ? poly_in[l*LANE_W +: LANE_W] : '0;
      sp_l = spill_hit ? spill_q[l*LANE_W +: LANE_W] : '0;
      p_l  = lo_l + sp_l;
      be_l = b_in[l*LANE_W +: LANE_W] + e_in[l*LANE_W +: LANE_W];
      if (mode_eff) begin
        sum_d[l*LANE_W +: LANE_W] = be_l - p_l;
      end else begin
        sum_d[l*LANE_W +: LANE_W] = be_l + p_l;
      end
    end
  end

  // Output register, spill register and frame mode register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
      sum_idx_q   <= '0;
      sum_last_q  <= 1'b0;
      spill_q     <= '0;
      spill_idx_q <= '0;
      spill_vld_q <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      if (fire_emit) begin
        sum_valid_q <= 1'b1;
        sum_q       <= sum_d;
        sum_idx_q   <= e_idx;
        sum_last_q  <= (e_idx == LAST_IDX);
      end else if (sum_ready) begin
        sum_valid_q <= 1'b0;
      end
      if (fire_match) begin
        spill_q     <= poly_in[2*W-1:W];
        spill_idx_q <= poly_idx;
        spill_vld_q <= 1'b1;
      end
      if (fire_emit && frame_start) begin
        mode_q <= mode_sub;
      end
    end
  end

  assign sum_valid = sum_valid_q;
  assign sum       = sum_q;
  assign sum_idx   = sum_idx_q;
  assign sum_last  = sum_last_q;

`ifdef PCOMB_STATS_EN
  logic [IDX_W-1:0] drop_cnt_q;
  logic [IDX_W-1:0] fill_cnt_q;

  // Saturating DROP/FILL counters, restarted by the first word of each frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_cnt_q <= '0;
      fill_cnt_q <= '0;
    end else if (fire_emit && frame_start) begin
      drop_cnt_q <= '0;
      fill_cnt_q <= fire_fill ? IDX_W'(1) : '0;
    end else begin
      if (fire_drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + IDX_W'(1);
      end
      if (fire_fill && (fill_cnt_q != '1)) begin
        fill_cnt_q <= fill_cnt_q + IDX_W'(1);
      end
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign fill_cnt = fill_cnt_q;
`endif

endmodule

// File: tb/tb_poly_lane_combiner.sv
// tb_poly_lane_combiner
//   Directed-vector bench for poly_lane_combiner (LANES=4, LANE_W=6,
//   DEPTH=784, IDX_W=10). Expected values are hand computed per lane.
//   Inputs change 1 time unit after the rising edge; combinational readys
//   and registered outputs are sampled away from the rising edge.

module tb_poly_lane_combiner;

  localparam int LANES  = 4;
  localparam int LANE_W = 6;
  localparam int W      = LANES * LANE_W;
  localparam int IDX_W  = 10;
  localparam int DEPTH  = 784;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             poly_valid;
  logic [2*W-1:0]   poly_in;
  logic [IDX_W-1:0] poly_idx;
  logic             poly_ready;
  logic             e_valid;
  logic [W-1:0]     e_in;
  logic [IDX_W-1:0] e_idx;
  logic             e_ready;
  logic             b_valid;
  logic [W-1:0]     b_in;
  logic             b_ready;
  logic             mode_sub;
  logic             sum_ready;
  logic             sum_valid;
  logic [W-1:0]     sum;
  logic [IDX_W-1:0] sum_idx;
  logic             sum_last;
`ifdef PCOMB_STATS_EN
  logic [IDX_W-1:0] drop_cnt;
  logic [IDX_W-1:0] fill_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int last_cnt = 0;

  poly_lane_combiner #(
    .LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .poly_valid(poly_valid), .poly_in(poly_in), .poly_idx(poly_idx), .poly_ready(poly_ready),
    .e_valid(e_valid), .e_in(e_in), .e_idx(e_idx), .e_ready(e_ready),
    .b_valid(b_valid), .b_in(b_in), .b_ready(b_ready),
    .mode_sub(mode_sub), .sum_ready(sum_ready),
    .sum_valid(sum_valid), .sum(sum), .sum_idx(sum_idx), .sum_last(sum_last)
`ifdef PCOMB_STATS_EN
    , .drop_cnt(drop_cnt), .fill_cnt(fill_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Count handshaken last words to catch lost or duplicated frame ends.
  always @(posedge clk_in) begin
    if (!rst_in && sum_valid && sum_ready && sum_last) last_cnt <= last_cnt + 1;
  end

  function automatic logic [W-1:0] rep(input logic [LANE_W-1:0] v);
    return {LANES{v}};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    poly_valid = 1'b0;
    e_valid    = 1'b0;
    b_valid    = 1'b0;
  endtask

  task automatic word(input logic [IDX_W-1:0] ei, input logic [W-1:0] bv, input logic [W-1:0] ev,
                      input logic [IDX_W-1:0] pi, input logic [W-1:0] hi, input logic [W-1:0] lo);
    e_valid    = 1'b1;
    b_valid    = 1'b1;
    poly_valid = 1'b1;
    e_idx      = ei;
    b_in       = bv;
    e_in       = ev;
    poly_idx   = pi;
    poly_in    = {hi, lo};
  endtask

  task automatic chk_rdy(input string tag, input logic p, input logic e);
    #1;
    check_eq({tag, ".poly_ready"}, {31'd0, poly_ready}, {31'd0, p});
    check_eq({tag, ".e_ready"},    {31'd0, e_ready},    {31'd0, e});
    check_eq({tag, ".b_ready"},    {31'd0, b_ready},    {31'd0, e});
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [W-1:0] s,
                         input logic [IDX_W-1:0] idx, input logic last);
    check_eq({tag, ".sum_valid"}, {31'd0, sum_valid}, {31'd0, v});
    check_eq({tag, ".sum"},       {8'd0, sum},        {8'd0, s});
    check_eq({tag, ".sum_idx"},   {22'd0, sum_idx},   {22'd0, idx});
    check_eq({tag, ".sum_last"},  {31'd0, sum_last},  {31'd0, last});
  endtask

  initial begin
    rst_in    = 1'b1;
    idle();
    poly_in   = '0;
    poly_idx  = '0;
    e_in      = '0;
    e_idx     = '0;
    b_in      = '0;
    mode_sub  = 1'b0;
    sum_ready = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    chk_out("reset", 1'b0, 24'h0, 10'd0, 1'b0);
    rst_in = 1'b0;
    chk_rdy("idle", 1'b0, 1'b0);

    // MATCH without spill: 1 + 2 + 3 = 6 in every lane, one-cycle latency.
    word(10'd0, 24'h041041, 24'h082082, 10'd0, 24'h0, 24'h0C30C3);
    chk_rdy("match", 1'b1, 1'b1);
    tick();
    chk_out("match", 1'b1, 24'h186186, 10'd0, 1'b0);

    // Spill carry, add mode: hi of idx0 (5) plus lo of idx1 (1).
    word(10'd0, 24'h0, 24'h0, 10'd0, rep(6'd5), 24'h0);
    tick();
    chk_out("spill_add0", 1'b1, 24'h0, 10'd0, 1'b0);
    word(10'd1, 24'h0, 24'h0, 10'd1, 24'h0, rep(6'd1));
    tick();
    chk_out("spill_add1", 1'b1, rep(6'd6), 10'd1, 1'b0);

    // Spill carry, subtract mode held for the frame: 0 - 6 = 58.
    mode_sub = 1'b1;
    word(10'd0, 24'h0, 24'h0, 10'd0, rep(6'd5), 24'h0);
    tick();
    chk_out("spill_sub0", 1'b1, 24'h0, 10'd0, 1'b0);
    mode_sub = 1'b0;
    word(10'd1, 24'h0, 24'h0, 10'd1, 24'h0, rep(6'd1));
    tick();
    chk_out("spill_sub1", 1'b1, rep(6'd58), 10'd1, 1'b0);

    // FILL: poly idx2 arrives while e_idx=1, then MATCHes at e_idx=2.
    word(10'd0, 24'h0, 24'h0, 10'd0, 24'h0, 24'h0);
    tick();
    word(10'd1, rep(6'd1), rep(6'd3), 10'd2, rep(6'd7), rep(6'd2));
    chk_rdy("fill", 1'b0, 1'b1);
    tick();
    chk_out("fill", 1'b1, rep(6'd4), 10'd1, 1'b0);
`ifdef PCOMB_STATS_EN
    check_eq("fill_cnt", {22'd0, fill_cnt}, 32'd1);
`endif
    word(10'd2, 24'h0, 24'h0, 10'd2, rep(6'd7), rep(6'd2));
    chk_rdy("fill_match", 1'b1, 1'b1);
    tick();
    chk_out("fill_match", 1'b1, rep(6'd2), 10'd2, 1'b0);

    // DROP: poly idx5 behind e_idx6 is consumed alone, no output.
    word(10'd6, 24'h0, 24'h0, 10'd5, 24'h0, rep(6'd9));
    chk_rdy("drop", 1'b1, 1'b0);
    tick();
    check_eq("drop.sum_valid", {31'd0, sum_valid}, 32'd0);
`ifdef PCOMB_STATS_EN
    check_eq("drop_cnt", {22'd0, drop_cnt}, 32'd1);
`endif

    // Lane overflow: 63 + 63 + 63 = 189 = 61 mod 64, no inter-lane carry.
    word(10'd0, rep(6'd63), rep(6'd63), 10'd0, 24'h0, rep(6'd63));
    tick();
    chk_out("wrap", 1'b1, rep(6'd61), 10'd0, 1'b0);

    // Backpressure across the DEPTH-1 -> 0 boundary.
    word(10'd782, 24'h0, 24'h0, 10'd782, 24'h0, rep(6'd10));
    tick();
    chk_out("bp_782", 1'b1, rep(6'd10), 10'd782, 1'b0);
    sum_ready = 1'b0;
    word(10'd783, 24'h0, 24'h0, 10'd700, 24'h0, rep(6'd20));
    chk_rdy("bp_drop", 1'b1, 1'b0);
    tick();
    chk_out("bp_hold", 1'b1, rep(6'd10), 10'd782, 1'b0);
    word(10'd783, 24'h0, 24'h0, 10'd783, 24'h0, rep(6'd20));
    for (int k = 0; k < 3; k++) begin
      chk_rdy("bp_stall", 1'b0, 1'b0);
      tick();
      chk_out("bp_hold", 1'b1, rep(6'd10), 10'd782, 1'b0);
    end
    sum_ready = 1'b1;
    chk_rdy("bp_release", 1'b1, 1'b1);
    tick();
    chk_out("bp_783", 1'b1, rep(6'd20), 10'd783, 1'b1);
    word(10'd0, 24'h0, 24'h0, 10'd0, 24'h0, rep(6'd30));
    tick();
    chk_out("bp_next0", 1'b1, rep(6'd30), 10'd0, 1'b0);
    idle();
    tick();
    check_eq("bp_drain.sum_valid", {31'd0, sum_valid}, 32'd0);
    check_eq("bp_last_pulses", last_cnt, 32'd1);

    // Async reset between edges while a word is stalled at the output.
    mode_sub = 1'b1;
    word(10'd0, rep(6'd4), 24'h0, 10'd0, rep(6'd5), 24'h0);
    tick();
    chk_out("pre_rst", 1'b1, rep(6'd4), 10'd0, 1'b0);
    sum_ready = 1'b0;
    mode_sub  = 1'b0;
    idle();
    #3 rst_in = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 24'h0, 10'd0, 1'b0);
    #2 rst_in = 1'b0;
    sum_ready = 1'b1;
    // With mode and spill cleared, idx1 is a plain add of lo only.
    word(10'd1, 24'h0, 24'h0, 10'd1, 24'h0, rep(6'd1));
    tick();
    chk_out("post_rst", 1'b1, rep(6'd1), 10'd1, 1'b0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_lane_combiner.md
Name: poly_lane_combiner

Overview:
- Parametrised successor to the packed b+e+poly adder in the encrypt datapath; sits after the polynomial multiplier.
- Combines a sparse, index-tagged poly product stream with dense, index-aligned e/b streams into lane-packed sums, modulo 2^LANE_W per lane.
- Adds over the previous generation: spill-half carry into the next index, zero-fill for missing poly indices, per-frame add/subtract mode and a full ready/valid output handshake.

Parameters:
- LANES, 4, number of packed coefficient lanes per word
- LANE_W, 6, bits per lane; all arithmetic is modulo 2^LANE_W per lane, no carry between lanes
- DEPTH, 784, words per frame; index range 0..DEPTH-1
- IDX_W, 10, index width; must satisfy 2^IDX_W >= DEPTH

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- poly_valid  in  1  poly word valid
- poly_in  in  2*LANES*LANE_W  [W-1:0] = lo half (this index), [2W-1:W] = hi spill (index+1), where W = LANES*LANE_W
- poly_idx  in  IDX_W  poly word index; strictly increasing within a frame, may skip
- poly_ready  out  1  poly word consumed this cycle
- e_valid  in  1  e word valid
- e_in  in  LANES*LANE_W  e word
- e_idx  in  IDX_W  e index; dense, 0..DEPTH-1 in order
- e_ready  out  1  e consumed
- b_valid  in  1  b word valid; index implied equal to e_idx
- b_in  in  LANES*LANE_W  b word
- b_ready  out  1  b consumed (always equal to e_ready)
- mode_sub  in  1  0: b+e+p, 1: b+e-p; sampled when e_idx==0 is consumed
- sum_ready  in  1  downstream ready
- sum_valid  out  1  sum word valid
- sum  out  LANES*LANE_W  result word
- sum_idx  out  IDX_W  result index
- sum_last  out  1  high with sum_idx==DEPTH-1

Behaviour:
- Reset (async, any time): sum_valid=0, sum=0, sum_idx=0, sum_last=0, spill register=0, spill_vld=0, mode register=0.
- ready outputs are combinational. out_free = !sum_valid || sum_ready.
- Decision, evaluated every cycle when out_free, b_valid and e_valid are all high:
  - MATCH: poly_valid && poly_idx==e_idx -> consume poly, e and b; p = lo + spill_term.
  - FILL: poly_valid && poly_idx>e_idx -> consume e and b only; p = spill_term (lo treated as 0).
  - DROP: poly_valid && poly_idx<e_idx -> consume poly only; no output; spill register unchanged.
  - !poly_valid -> stall; all readys low.
- If out_free, b_valid or e_valid is low: poly_ready=e_ready=b_ready=0, except DROP, which needs only poly_valid (DROP may fire while the output is stalled).
- spill_term = spill register if spill_vld && spill_idx==e_idx-1, else 0.
- On MATCH: spill register <= hi half, spill_idx <= poly_idx, spill_vld <= 1.
- On FILL or MATCH at e_idx==0: any stale spill is ignored. The spill of index DEPTH-1 is discarded, with no negacyclic wrap.
- Mode register loads mode_sub on the consume at e_idx==0 and is held for the whole frame.
- Per-lane arithmetic: s_l = b_l + e_l + (mode ? -p_l : p_l) mod 2^LANE_W, where p_l = lo_l + spill_l mod 2^LANE_W.
- Latency: a MATCH or FILL fire at cycle N gives sum_valid=1 at N+1 with sum_idx=e_idx and sum_last=(e_idx==DEPTH-1).
- Output hold: sum/sum_idx/sum_last are held stable while sum_valid && !sum_ready. sum_valid drops the cycle after a handshake unless a new fire occurs in the same cycle, which gives back-to-back throughput of 1 word/cycle.
- After e_idx DEPTH-1 is consumed, the next expected e_idx is 0. poly words with idx < e_idx still DROP, so leftover poly from the previous frame is flushed.

Optional Feature:
- PCOMB_STATS_EN defined:
  - Adds outputs drop_cnt[IDX_W-1:0] and fill_cnt[IDX_W-1:0], counting DROP and FILL events.
  - Both cleared at reset and on the consume at e_idx==0 (the clear takes precedence over the increment, and that event counts as 1 if it is a FILL).
  - Both saturate at all-ones.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- MATCH, no spill: LANES=4, LANE_W=6, mode=0, idx0, b=0x041041 (all lanes 1), e=0x082082 (2), poly lo=0x0C30C3 (3), hi=0 -> sum=0x186186 (6), sum_idx=0, 1-cycle latency.
- Spill carry: idx0 poly hi=all lanes 5; idx1 lo=all 1, b=e=0 -> sum at idx1 = all lanes 6. Repeat with mode_sub=1 -> all lanes 58 (0x3A).
- FILL: poly arrives idx 2 while e_idx=1, spill from idx0 -> idx1 output = b+e only; fill_cnt=1 (with PCOMB_STATS_EN); poly idx2 then MATCHes.
- DROP + wrap: poly idx 5 presented with e_idx=6 -> poly_ready=1 with e_ready=0, no output. Lane overflow: all lanes 63+63+63 -> 61 (0x3D), with no inter-lane carry.
- Backpressure: hold sum_ready=0 for 4 cycles -> sum stable, all readys 0 except DROP; release -> back-to-back words, no loss or duplication across a DEPTH-1 -> 0 boundary (sum_last pulse once).
- Async reset asserted mid-frame between clock edges -> sum_valid=0 immediately. After release, mode/spill are cleared and the frame restarts at e_idx 0.
